i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Shares one I2C master engine among NUM_REQ requesters. Requester examples: sensor poller, config loader, debug port.
- Round-robin arbitration over pending requests.
- Latches the winner's address, data and R/W, issues one start pulse to the master, then waits for its done/nack.
- Returns a per-requester completion pulse with status and read data.
- Runs entirely in the sclk domain of the master it feeds.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, max sclk cycles in WAIT before abort; width = clog2(TIMEOUT+1).
- MAX_RETRY, 2, NACK retries per transaction (only with I2C_ARB_RETRY_EN).

Ports:
- sclk  in  1  block clock (I2C bit clock domain).
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until its done pulse.
- req_addr  in  7*NUM_REQ  7-bit slave address; requester i uses bits [7i+6:7i].
- req_data  in  8*NUM_REQ  write byte; requester i uses bits [8i+7:8i].
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- gnt  out  NUM_REQ  one-hot; high while requester owns the master.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- err  out  NUM_REQ  status, valid with done: 1 = nack or timeout.
- rdata  out  8  read byte, valid with done when rw=1 and err=0.
- m_start  out  1  one-cycle start pulse to the master.
- m_addr  out  7  latched address.
- m_data  out  8  latched write byte.
- m_rw  out  1  latched direction.
- m_busy  in  1  master mid-transaction.
- m_done  in  1  one-cycle pulse, transaction finished.
- m_nack  in  1  valid with m_done; slave did not acknowledge.
- m_rdata  in  8  valid with m_done on reads.

Behaviour:
- Reset (rst low, async) values:
  - All outputs 0.
  - State IDLE; rr_ptr 0 (requester 0 has highest priority first); timer 0; retry count 0.
- States: IDLE, GRANT, ISSUE, WAIT, RESP.
- IDLE:
  - If any req=1 and m_busy=0, pick the first set req at or after rr_ptr, wrapping modulo NUM_REQ.
  - Next cycle: set gnt one-hot, latch m_addr/m_data/m_rw from the winner's slice, go to GRANT.
  - If m_busy=1, stay in IDLE.
- GRANT: one cycle for latched operands to settle -> ISSUE.
- ISSUE: m_start=1 for exactly one cycle; timer cleared -> WAIT.
- WAIT:
  - Timer increments each cycle.
  - m_done=1: capture rdata<=m_rdata on reads; err<=m_nack; -> RESP.
  - Timer reaches TIMEOUT with no m_done: err<=1, rdata unchanged -> RESP.
- RESP:
  - done[owner]=1 for one cycle; err[owner] valid in the same cycle.
  - gnt cleared; rr_ptr <= owner+1 (wrap to 0 after NUM_REQ-1) -> IDLE.
- Latency from IDLE grant decision to m_start: 2 cycles. Minimum gap between back-to-back transactions: 1 IDLE cycle.
- A requester dropping req while granted: the transaction still completes; the done pulse is still issued and may be ignored.
- req changes after grant do not affect latched operands.
- m_done in any state other than WAIT is ignored.
- Simultaneous m_done and timeout expiry in the same cycle: m_done wins (err = m_nack).
- Fairness: a requester holding req continuously is serviced within NUM_REQ transactions.
- Reset mid-transaction returns to IDLE with all outputs 0. The master is reset by the same rst.

Optional Feature:
- Macro: I2C_ARB_RETRY_EN.
- Defined:
  - On m_done with m_nack=1 and retry count < MAX_RETRY: increment retry count, return to ISSUE (new m_start, gnt held, no done pulse).
  - After MAX_RETRY failed retries: RESP with err=1.
  - Retry count clears on entering GRANT.
  - Timeout is never retried.
- Not defined: nack goes directly to RESP with err=1; retry counter logic absent.

Test Plan:
- Single write: req[1]=1, addr 0x50, data 0xA5, rw 0; master returns m_done, m_nack=0.
  - Required: gnt=0010, then m_start 2 cycles later with m_addr=0x50, m_data=0xA5, m_rw=0; done[1] pulse, err[1]=0.
- Read: req[2], rw=1, m_rdata=0x3C with m_done -> rdata=0x3C, done[2]=1, err=0.
- Round-robin: req=1111 held continuously -> grants in order 0,1,2,3,0; each done pulse exactly once per grant.
- Nack:
  - Without macro: m_nack=1 -> done with err=1 after exactly 1 m_start.
  - With I2C_ARB_RETRY_EN, MAX_RETRY=2, always nack: 3 m_start pulses, then err=1.
- Timeout: TIMEOUT=15, master never pulses m_done -> done with err=1 exactly 16 cycles after m_start; arbiter back in IDLE.
- Reset: assert rst low during WAIT -> gnt, done, m_start immediately 0; after release, a pending req[0] is granted first.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master engine among NUM_REQ requesters.
// Optional NACK retry is enabled by defining I2C_ARB_RETRY_EN.
//
// state  | meaning
// IDLE   | waiting for a pending request while the master is not busy
// GRANT  | owner granted, latched operands settle
// ISSUE  | one-cycle start pulse to the master
// WAIT   | waiting for master done/nack or timeout
// RESP   | done/err pulse to the owner, advance round-robin pointer
module i2c_txn_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int TIMEOUT   = 1023,
   parameter int MAX_RETRY = 2
) (
   input  logic                 sclk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [7*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_rw,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic [NUM_REQ-1:0]   err,
   output logic [7:0]           rdata,
   output logic                 m_start,
   output logic [6:0]           m_addr,
   output logic [7:0]           m_data,
   output logic                 m_rw,
   input  logic                 m_busy,
   input  logic                 m_done,
   input  logic                 m_nack,
   input  logic [7:0]           m_rdata
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner;
   logic [TW-1:0]   timer;
   logic [IW-1:0]   pick_idx;
   logic            pick_vld;
   logic            retry_now;
   int unsigned     k;

`ifdef I2C_ARB_RETRY_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0]   retry_cnt;

   assign retry_now = m_nack && (retry_cnt < RW'(MAX_RETRY));
`else
   assign retry_now = 1'b0;
`endif

   // Scan from the highest offset down so the closest requester at or after rr_ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      k        = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = (32'(rr_ptr) + 32'(i)) % 32'(NUM_REQ);
         if (req[k]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(k);
         end
      end
   end

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         rr_ptr  <= '0;
         owner   <= '0;
         timer   <= '0;
         gnt     <= '0;
         done    <= '0;
         err     <= '0;
         rdata   <= '0;
         m_start <= 1'b0;
         m_addr  <= '0;
         m_data  <= '0;
         m_rw    <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
         retry_cnt <= '0;
`endif
      end else begin
         m_start <= 1'b0;
         done    <= '0;
         err     <= '0;
         case (state)
            S_IDLE: begin
               if (pick_vld && !m_busy) begin
                  owner  <= pick_idx;
                  gnt    <= NUM_REQ'(1) << pick_idx;
                  m_addr <= req_addr[pick_idx*7 +: 7];
                  m_data <= req_data[pick_idx*8 +: 8];
                  m_rw   <= req_rw[pick_idx];
`ifdef I2C_ARB_RETRY_EN
                  retry_cnt <= '0;
`endif
                  state  <= S_GRANT;
               end
            end
            S_GRANT: begin
               m_start <= 1'b1;
               state   <= S_ISSUE;
            end
            S_ISSUE: begin
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               if (m_done && retry_now) begin
`ifdef I2C_ARB_RETRY_EN
                  retry_cnt <= retry_cnt + 1'b1;
`endif
                  m_start <= 1'b1;
                  state   <= S_ISSUE;
               end else if (m_done) begin
                  if (m_rw) begin
                     rdata <= m_rdata;
                  end
                  err[owner]  <= m_nack;
                  done[owner] <= 1'b1;
                  state       <= S_RESP;
               end else if (timer == T_LAST) begin
                  // Timeout is terminal; it never re-enters ISSUE.
                  err[owner]  <= 1'b1;
                  done[owner] <= 1'b1;
                  state       <= S_RESP;
               end
            end
            S_RESP: begin
               gnt    <= '0;
               rr_ptr <= (owner == I_LAST) ? '0 : owner + 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: directed scenarios plus randomized
// transactions compared against a round-robin reference model.
module tb_i2c_txn_arbiter;

   localparam int N   = 4;
   localparam int TMO = 15;
   localparam int MR  = 2;
`ifdef I2C_ARB_RETRY_EN
   localparam int NSTART = MR + 1;
`else
   localparam int NSTART = 1;
`endif

   logic           sclk;
   logic           rst;
   logic [N-1:0]   req;
   logic [7*N-1:0] req_addr;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_rw;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [N-1:0]   err;
   logic [7:0]     rdata;
   logic           m_start;
   logic [6:0]     m_addr;
   logic [7:0]     m_data;
   logic           m_rw;
   logic           m_busy;
   logic           m_done;
   logic           m_nack;
   logic [7:0]     m_rdata;

   i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
      .sclk(sclk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
      .req_rw(req_rw), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw),
      .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   logic [6:0] ta [N];
   logic [7:0] td [N];
   logic       trw [N];
   int         n_chk;
   int         n_fail;
   int         ptr;
   logic [7:0] rd_model;

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_addr[7*i +: 7] = ta[i];
         req_data[8*i +: 8] = td[i];
         req_rw[i]          = trw[i];
      end
   endtask

   // Reference rule: first pending requester at or after the pointer, modulo N.
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   // d < 0: master never answers. Otherwise m_done comes d cycles after m_start.
   task automatic do_txn(input int d, input bit nack, input logic [7:0] rd);
      int         w;
      int         n;
      int         starts;
      logic [N-1:0] oh;
      logic [6:0] ea;
      logic [7:0] ed;
      logic       erw;
      bit         exp_err;
      w  = pick(req, ptr);
      oh = N'(1) << w;
      n  = 0;
      while (gnt == '0 && n < 20) begin
         tick();
         n++;
      end
      chk("gnt_latency", 32'(n), 32'd1);
      chk("gnt_winner", 32'(gnt), 32'(oh));
      ea  = ta[w];
      ed  = td[w];
      erw = trw[w];
      chk("m_addr", 32'(m_addr), 32'(ea));
      chk("m_data", 32'(m_data), 32'(ed));
      chk("m_rw", 32'(m_rw), 32'(erw));
      ta[w] = 7'($urandom);
      td[w] = 8'($urandom);
      pack();
      tick();
      chk("m_start", 32'(m_start), 32'd1);
      chk("m_addr_held", 32'(m_addr), 32'(ea));
      if (d < 0) begin
         n = 0;
         while (done == '0 && n < 40) begin
            tick();
            n++;
         end
         chk("timeout_latency", 32'(n), 32'(TMO + 1));
         exp_err = 1'b1;
      end else begin
         starts = 1;
         for (int s = 0; s < NSTART + 2; s++) begin
            repeat (d) tick();
            m_done  = 1'b1;
            m_nack  = nack;
            m_rdata = rd;
            tick();
            m_done  = 1'b0;
            m_nack  = 1'b0;
            if (m_start !== 1'b1) break;
            starts++;
         end
         chk("start_count", 32'(starts), nack ? 32'(NSTART) : 32'd1);
         if (erw) rd_model = rd;
         exp_err = nack;
      end
      chk("done", 32'(done), 32'(oh));
      chk("err", 32'(err), exp_err ? 32'(oh) : 32'd0);
      chk("rdata", 32'(rdata), 32'(rd_model));
      chk("gnt_resp", 32'(gnt), 32'(oh));
      tick();
      chk("done_pulse", 32'(done), 32'd0);
      chk("gnt_idle", 32'(gnt), 32'd0);
      ptr = (w + 1) % N;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      ptr      = 0;
      rd_model = 8'h00;
      rst      = 1'b0;
      req      = '0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_nack   = 1'b0;
      m_rdata  = '0;
      for (int i = 0; i < N; i++) begin
         ta[i]  = 7'h10 + 7'(i);
         td[i]  = 8'(8'h80 + i);
         trw[i] = 1'b0;
      end
      pack();
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_m_start", 32'(m_start), 32'd0);
      chk("rst_m_addr", 32'(m_addr), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_m_rw", 32'(m_rw), 32'd0);
      rst = 1'b1;

      // Round robin with all requests held: 0,1,2,3,0.
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         chk("rr_order", 32'(pick(req, ptr)), 32'(i % N));
         do_txn(2, 1'b0, 8'($urandom));
      end
      req = '0;

      // Single write from requester 1.
      ta[1] = 7'h50; td[1] = 8'hA5; trw[1] = 1'b0; pack();
      req = 4'b0010;
      do_txn(3, 1'b0, 8'h77);
      req = '0;

      // Read from requester 2.
      ta[2] = 7'h2A; trw[2] = 1'b1; pack();
      req = 4'b0100;
      do_txn(4, 1'b0, 8'h3C);
      req = '0;
      chk("read_rdata", 32'(rdata), 32'h3C);

      // Nack from requester 3.
      trw[3] = 1'b0; pack();
      req = 4'b1000;
      do_txn(2, 1'b1, 8'h00);
      req = '0;

      // Timeout on requester 0.
      trw[0] = 1'b1; pack();
      req = 4'b0001;
      do_txn(-1, 1'b0, 8'h00);
      req = '0;

      // m_done on the last cycle before timeout wins.
      req = 4'b0010;
      do_txn(TMO, 1'b0, 8'h5A);
      req = '0;

      // Busy master holds off the grant.
      m_busy = 1'b1;
      req = 4'b0100;
      repeat (4) tick();
      chk("busy_hold", 32'(gnt), 32'd0);
      m_busy = 1'b0;
      do_txn(1, 1'b0, 8'hC3);
      req = '0;

      // Stray m_done while idle is ignored.
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      tick();
      chk("stray_done", 32'(done), 32'd0);
      chk("stray_gnt", 32'(gnt), 32'd0);

      // Randomized transactions.
      for (int it = 0; it < 30; it++) begin
         int r;
         for (int i = 0; i < N; i++) begin
            ta[i]  = 7'($urandom);
            td[i]  = 8'($urandom);
            trw[i] = 1'($urandom);
         end
         pack();
         req = N'($urandom_range(1, (1 << N) - 1));
         r = $urandom_range(0, 9);
         if (r == 0) do_txn(-1, 1'b0, 8'h00);
         else do_txn($urandom_range(1, TMO), r == 1, 8'($urandom));
      end
      req = '0;

      // Reset during WAIT: pointer returns to 0.
      req = 4'b0001;
      do_txn(1, 1'b0, 8'h11);
      req = 4'b0101;
      tick();
      chk("pre_rst_gnt", 32'(gnt), 32'b0100);
      tick();
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_m_start", 32'(m_start), 32'd0);
      chk("mid_rst_m_addr", 32'(m_addr), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      ptr = 0;
      rd_model = 8'h00;
      do_txn(2, 1'b0, 8'h22);
      req = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
